pwm32_core: RTL and testbench

//  PWM generator fed by the APB PWM32 register block; consumes PRE, TMRCMP1, TMRCMP2, TMREN.

---
 rtl/pwm32_if.sv | 25 ++
 rtl/pwm32_core.sv | 116 +++++++++++
 tb/tb_pwm32_core.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pwm32_if.sv
// pwm32_if: connection between the APB PWM32 register block and the PWM core.
// Carries the prescaler/compare/enable fields and the core's status outputs.
// The master side (register block) drives configuration; the slave side (core)
// consumes it and drives pwm_out, period_tick and tmr_value.
interface pwm32_if #(
  parameter int CNT_W = 32
);
  logic [CNT_W-1:0] PRE;
  logic [CNT_W-1:0] TMRCMP1;
  logic [CNT_W-1:0] TMRCMP2;
  logic             TMREN;
  logic             pwm_out;
  logic             period_tick;
  logic [CNT_W-1:0] tmr_value;

  modport master (
    output PRE, TMRCMP1, TMRCMP2, TMREN,
    input  pwm_out, period_tick, tmr_value
  );

  modport slave (
    input  PRE, TMRCMP1, TMRCMP2, TMREN,
    output pwm_out, period_tick, tmr_value
  );
endinterface

// File: rtl/pwm32_core.sv
// pwm32_core: prescaled 32-bit PWM generator.
// Period is TMRCMP1+1 timer ticks, high time is TMRCMP2 ticks, a timer tick
// happens every PRE+1 PCLK cycles. pwm_out and period_tick are registered.
// Build option PWM32_SHADOW_EN: compare values are shadowed and only updated
// while disabled or on a timer wrap, so mid-period writes never glitch the pin.
module pwm32_core #(
  parameter int CNT_W = 32
) (
  input  logic     PCLK,
  input  logic     PRESETn,
  pwm32_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] pre_cnt_d, pre_cnt_q;
  logic [CNT_W-1:0] tmr_d, tmr_q;
  logic             pwm_d, pwm_q;
  logic             period_tick_d, period_tick_q;
  logic             tick_s;
  logic             wrap_s;
  logic [CNT_W-1:0] cmp1_s;
  logic [CNT_W-1:0] cmp2_s;

`ifdef PWM32_SHADOW_EN
  logic [CNT_W-1:0] cmp1_d, cmp1_q;
  logic [CNT_W-1:0] cmp2_d, cmp2_q;

  // Reload the compare shadows while idle or at a period boundary only.
  always_comb begin
    cmp1_d = cmp1_q;
    cmp2_d = cmp2_q;
    if (!bus.TMREN || wrap_s) begin
      cmp1_d = bus.TMRCMP1;
      cmp2_d = bus.TMRCMP2;
    end else begin
      cmp1_d = cmp1_q;
      cmp2_d = cmp2_q;
    end
  end

  // Shadow compare registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cmp1_q <= CNT_ZERO;
      cmp2_q <= CNT_ZERO;
    end else begin
      cmp1_q <= cmp1_d;
      cmp2_q <= cmp2_d;
    end
  end

  assign cmp1_s = cmp1_q;
  assign cmp2_s = cmp2_q;
`else
  assign cmp1_s = bus.TMRCMP1;
  assign cmp2_s = bus.TMRCMP2;
`endif

  // Prescaler tick and timer wrap detection; >= so a lowered limit wraps at once.
  always_comb begin
    tick_s = bus.TMREN && (pre_cnt_q >= bus.PRE);
    wrap_s = tick_s && (tmr_q >= cmp1_s);
  end

  // Next-state for prescaler, timer, pin and period pulse; disable overrides all.
  always_comb begin
    pre_cnt_d     = CNT_ZERO;
    tmr_d         = CNT_ZERO;
    pwm_d         = 1'b0;
    period_tick_d = 1'b0;
    if (bus.TMREN) begin
      if (tick_s) begin
        pre_cnt_d = CNT_ZERO;
        if (wrap_s) begin
          tmr_d         = CNT_ZERO;
          period_tick_d = 1'b1;
        end else begin
          tmr_d         = tmr_q + CNT_ONE;
          period_tick_d = 1'b0;
        end
      end else begin
        pre_cnt_d     = pre_cnt_q + CNT_ONE;
        tmr_d         = tmr_q;
        period_tick_d = 1'b0;
      end
      pwm_d = (tmr_q < cmp2_s);
    end else begin
      pre_cnt_d     = CNT_ZERO;
      tmr_d         = CNT_ZERO;
      pwm_d         = 1'b0;
      period_tick_d = 1'b0;
    end
  end

  // Counter and output registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pre_cnt_q     <= CNT_ZERO;
      tmr_q         <= CNT_ZERO;
      pwm_q         <= 1'b0;
      period_tick_q <= 1'b0;
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      tmr_q         <= tmr_d;
      pwm_q         <= pwm_d;
      period_tick_q <= period_tick_d;
    end
  end

  assign bus.pwm_out     = pwm_q;
  assign bus.period_tick = period_tick_q;
  assign bus.tmr_value   = tmr_q;

endmodule

// File: tb/tb_pwm32_core.sv
// tb_pwm32_core: directed self-checking bench for pwm32_core.
// Inputs change 1 time unit after a rising edge; outputs are checked there too,
// so "edge k" below means the k-th rising edge after the enable went high.
module tb_pwm32_core;
  localparam int CNT_W = 32;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  pwm32_if #(.CNT_W(CNT_W)) bus ();

  pwm32_core #(.CNT_W(CNT_W)) u_dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus.slave)
  );

  always #5 PCLK = ~PCLK;

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // Disable for one edge with new settings, then enable; next edge is edge 1.
  task automatic restart(input logic [31:0] pre, input logic [31:0] c1, input logic [31:0] c2);
    bus.TMREN   = 1'b0;
    bus.PRE     = pre;
    bus.TMRCMP1 = c1;
    bus.TMRCMP2 = c2;
    step();
    bus.TMREN = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm got %b exp 0", bus.pwm_out); end
    checks++; if (bus.period_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", bus.period_tick); end
    checks++; if (bus.tmr_value !== 32'd0) begin errors++; $display("FAIL reset_tmr got %0d exp 0", bus.tmr_value); end
    @(negedge PCLK);
    PRESETn = 1'b1;
    step();
  endtask

  // PRE=0, CMP1=9, CMP2=3: 3 high / 7 low, wrap every 10 cycles.
  task automatic test_basic_pwm();
    restart(32'd0, 32'd9, 32'd3);
    for (int k = 1; k <= 30; k++) begin
      int  et;
      logic ep, ek;
      step();
      et = k % 10;
      ep = (et >= 1) && (et <= 3);
      ek = (et == 0);
      checks++; if (bus.tmr_value !== et) begin errors++; $display("FAIL basic_tmr k=%0d got %0d exp %0d", k, bus.tmr_value, et); end
      checks++; if (bus.pwm_out !== ep) begin errors++; $display("FAIL basic_pwm k=%0d got %b exp %b", k, bus.pwm_out, ep); end
      checks++; if (bus.period_tick !== ek) begin errors++; $display("FAIL basic_tick k=%0d got %b exp %b", k, bus.period_tick, ek); end
    end
  endtask

  // PRE=1: timer steps every 2 cycles, 6 high / 14 low, wrap every 20.
  task automatic test_prescale();
    restart(32'd1, 32'd9, 32'd3);
    for (int k = 1; k <= 40; k++) begin
      int  et;
      logic ep, ek;
      step();
      et = (k / 2) % 10;
      ep = ((k - 1) % 20) < 6;
      ek = (k % 20) == 0;
      checks++; if (bus.tmr_value !== et) begin errors++; $display("FAIL pre_tmr k=%0d got %0d exp %0d", k, bus.tmr_value, et); end
      checks++; if (bus.pwm_out !== ep) begin errors++; $display("FAIL pre_pwm k=%0d got %b exp %b", k, bus.pwm_out, ep); end
      checks++; if (bus.period_tick !== ek) begin errors++; $display("FAIL pre_tick k=%0d got %b exp %b", k, bus.period_tick, ek); end
    end
  endtask

  // Duty compare boundaries: 0 -> never high, above period -> always high, CMP1=0.
  task automatic test_duty_limits();
    restart(32'd0, 32'd9, 32'd0);
    for (int k = 1; k <= 20; k++) begin
      step();
      checks++; if (bus.pwm_out !== 1'b0) begin errors++; $display("FAIL cmp2zero_pwm k=%0d got %b exp 0", k, bus.pwm_out); end
    end
    restart(32'd0, 32'd9, 32'd20);
    checks++; if (bus.pwm_out !== 1'b0) begin errors++; $display("FAIL cmp2big_first got %b exp 0", bus.pwm_out); end
    for (int k = 1; k <= 20; k++) begin
      step();
      checks++; if (bus.pwm_out !== 1'b1) begin errors++; $display("FAIL cmp2big_pwm k=%0d got %b exp 1", k, bus.pwm_out); end
    end
    restart(32'd0, 32'd0, 32'd1);
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++; if (bus.tmr_value !== 32'd0) begin errors++; $display("FAIL cmp1zero_tmr k=%0d got %0d exp 0", k, bus.tmr_value); end
      checks++; if (bus.pwm_out !== 1'b1) begin errors++; $display("FAIL cmp1zero_pwm k=%0d got %b exp 1", k, bus.pwm_out); end
      checks++; if (bus.period_tick !== 1'b1) begin errors++; $display("FAIL cmp1zero_tick k=%0d got %b exp 1", k, bus.period_tick); end
    end
  endtask

  // Disable mid-period, re-enable, and disable coinciding with a wrap.
  task automatic test_disable();
    restart(32'd0, 32'd9, 32'd3);
    repeat (5) step();
    checks++; if (bus.tmr_value !== 32'd5) begin errors++; $display("FAIL dis_pre_tmr got %0d exp 5", bus.tmr_value); end
    bus.TMREN = 1'b0;
    step();
    checks++; if (bus.tmr_value !== 32'd0) begin errors++; $display("FAIL dis_tmr got %0d exp 0", bus.tmr_value); end
    checks++; if (bus.pwm_out !== 1'b0) begin errors++; $display("FAIL dis_pwm got %b exp 0", bus.pwm_out); end
    checks++; if (bus.period_tick !== 1'b0) begin errors++; $display("FAIL dis_tick got %b exp 0", bus.period_tick); end
    bus.TMREN = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      int  et;
      logic ep, ek;
      step();
      et = k % 10;
      ep = (et >= 1) && (et <= 3);
      ek = (et == 0);
      checks++; if (bus.tmr_value !== et) begin errors++; $display("FAIL reen_tmr k=%0d got %0d exp %0d", k, bus.tmr_value, et); end
      checks++; if (bus.pwm_out !== ep) begin errors++; $display("FAIL reen_pwm k=%0d got %b exp %b", k, bus.pwm_out, ep); end
      checks++; if (bus.period_tick !== ek) begin errors++; $display("FAIL reen_tick k=%0d got %b exp %b", k, bus.period_tick, ek); end
    end
    restart(32'd0, 32'd9, 32'd3);
    repeat (9) step();
    checks++; if (bus.tmr_value !== 32'd9) begin errors++; $display("FAIL wrapdis_pre_tmr got %0d exp 9", bus.tmr_value); end
    bus.TMREN = 1'b0;
    step();
    checks++; if (bus.period_tick !== 1'b0) begin errors++; $display("FAIL wrapdis_tick got %b exp 0", bus.period_tick); end
    checks++; if (bus.tmr_value !== 32'd0) begin errors++; $display("FAIL wrapdis_tmr got %0d exp 0", bus.tmr_value); end
  endtask

  // CMP2 raised 3 -> 6 while tmr=4.
  task automatic test_duty_update();
    restart(32'd0, 32'd9, 32'd3);
    repeat (4) step();
    checks++; if (bus.tmr_value !== 32'd4) begin errors++; $display("FAIL upd_pre_tmr got %0d exp 4", bus.tmr_value); end
    bus.TMRCMP2 = 32'd6;
    for (int k = 5; k <= 20; k++) begin
      int  et;
      logic ep;
      step();
      et = k % 10;
`ifdef PWM32_SHADOW_EN
      ep = (k <= 10) ? (((k - 1) % 10) < 3) : (((k - 1) % 10) < 6);
`else
      ep = ((k - 1) % 10) < 6;
`endif
      checks++; if (bus.tmr_value !== et) begin errors++; $display("FAIL upd_tmr k=%0d got %0d exp %0d", k, bus.tmr_value, et); end
      checks++; if (bus.pwm_out !== ep) begin errors++; $display("FAIL upd_pwm k=%0d got %b exp %b", k, bus.pwm_out, ep); end
    end
  endtask

  // Asynchronous reset at tmr=7, then counting resumes with TMREN still high.
  task automatic test_async_reset();
    int off;
    restart(32'd0, 32'd9, 32'd3);
    repeat (7) step();
    checks++; if (bus.tmr_value !== 32'd7) begin errors++; $display("FAIL ares_pre_tmr got %0d exp 7", bus.tmr_value); end
    PRESETn = 1'b0;
    #1;
    checks++; if (bus.tmr_value !== 32'd0) begin errors++; $display("FAIL ares_tmr got %0d exp 0", bus.tmr_value); end
    checks++; if (bus.pwm_out !== 1'b0) begin errors++; $display("FAIL ares_pwm got %b exp 0", bus.pwm_out); end
    checks++; if (bus.period_tick !== 1'b0) begin errors++; $display("FAIL ares_tick got %b exp 0", bus.period_tick); end
    #1;
    PRESETn = 1'b1;
`ifdef PWM32_SHADOW_EN
    // Shadows restart at 0, so the first edge is a zero-length wrap that loads them.
    off = 1;
    step();
    checks++; if (bus.tmr_value !== 32'd0) begin errors++; $display("FAIL ares_sh_tmr got %0d exp 0", bus.tmr_value); end
    checks++; if (bus.pwm_out !== 1'b0) begin errors++; $display("FAIL ares_sh_pwm got %b exp 0", bus.pwm_out); end
    checks++; if (bus.period_tick !== 1'b1) begin errors++; $display("FAIL ares_sh_tick got %b exp 1", bus.period_tick); end
`else
    off = 0;
`endif
    for (int j = 1; j <= 12; j++) begin
      int  et;
      logic ep, ek;
      step();
      et = j % 10;
      ep = (et >= 1) && (et <= 3);
      ek = (et == 0);
      checks++; if (bus.tmr_value !== et) begin errors++; $display("FAIL post_tmr j=%0d off=%0d got %0d exp %0d", j, off, bus.tmr_value, et); end
      checks++; if (bus.pwm_out !== ep) begin errors++; $display("FAIL post_pwm j=%0d got %b exp %b", j, bus.pwm_out, ep); end
      checks++; if (bus.period_tick !== ek) begin errors++; $display("FAIL post_tick j=%0d got %b exp %b", j, bus.period_tick, ek); end
    end
  endtask

  initial begin
    bus.PRE     = 32'd0;
    bus.TMRCMP1 = 32'd0;
    bus.TMRCMP2 = 32'd0;
    bus.TMREN   = 1'b0;
    test_reset();
    test_basic_pwm();
    test_prescale();
    test_duty_limits();
    test_disable();
    test_duty_update();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
